// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALUOp encodings, control/ID-EX structs and the main decoder
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int ALUOP_BITS = 4;

  typedef enum logic [ALUOP_BITS-1:0] {
    ALUOP_NONE  = 4'd0,
    ALUOP_ADD   = 4'd1,
    ALUOP_SUB   = 4'd2,
    ALUOP_RTYPE = 4'd3,
    ALUOP_AND   = 4'd4,
    ALUOP_OR    = 4'd5,
    ALUOP_SLT   = 4'd6,
    ALUOP_LUI   = 4'd7
  } aluop_e;

  typedef struct packed {
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    logic   alu_src;
    logic   reg_dst;
    aluop_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc2;
    ctrl_t       ctrl;
  } idex_t;

  localparam ctrl_t CTRL_NOP    = '0;
  localparam idex_t IDEX_BUBBLE = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALUOP_RTYPE; end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALUOP_ADD;
      end
      OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_BEQ, OP_BNE: c.alu_op = ALUOP_SUB;
      OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_ANDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_AND; end
      OP_ORI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_OR; end
      OP_SLTI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_SLT; end
      OP_LUI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_LUI; end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read 1-write GPR file, $0 hard-wired to zero, write-first bypass
module register_file #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // A writeback landing this cycle is visible to ID immediately.
  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 :
                 (we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 :
                 (we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - ID stage: decode, GPR read, hazard/branch resolution, ID/EX register
// Optional macro ID_FORWARD_EN: forward MEM_ALUResult into the branch comparator instead of stalling.
module instruction_decode_stage import mips_pkg::*; #(
  parameter int RF_DEPTH = 32,
  parameter int ALUOP_W  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        Instruction1,
  input  logic [31:0]        PC1,
  input  logic               EX_MemRead,
  input  logic               EX_RegWrite,
  input  logic [4:0]         EX_WriteReg,
  input  logic               MEM_MemRead,
  input  logic               MEM_RegWrite,
  input  logic [4:0]         MEM_WriteReg,
  input  logic [31:0]        MEM_ALUResult,
  input  logic               WB_RegWrite,
  input  logic [4:0]         WB_WriteReg,
  input  logic [31:0]        WB_Data,
  output logic               Stall,
  output logic               PCsrc,
  output logic [31:0]        BranchTarget,
  output logic [31:0]        ReadData1,
  output logic [31:0]        ReadData2,
  output logic [31:0]        Imm,
  output logic [4:0]         Rs,
  output logic [4:0]         Rt,
  output logic [4:0]         Rd,
  output logic [31:0]        PC2,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               ALUSrc,
  output logic               RegDst,
  output logic [ALUOP_W-1:0] ALUOp
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] imm_sext, imm_ext, rf_rd1, rf_rd2, br_op1, br_op2;
  logic [31:0] pc_plus4, br_target, j_target;
  logic        is_beq, is_bne, is_j, is_branch, uses_rs, uses_rt;
  logic        load_use, br_hazard, stall_raw, taken;
  ctrl_t       ctrl;
  idex_t       idex_d, idex_q;

  assign opcode   = Instruction1[31:26];
  assign rs       = Instruction1[25:21];
  assign rt       = Instruction1[20:16];
  assign rd       = Instruction1[15:11];
  assign imm16    = Instruction1[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign ctrl     = decode_ctrl(opcode);

  always_comb begin
    imm_ext = imm_sext;
    case (opcode)
      OP_ANDI, OP_ORI: imm_ext = {16'h0000, imm16};
      OP_LUI:          imm_ext = {imm16, 16'h0000};
      default:         imm_ext = imm_sext;
    endcase
  end

  register_file #(.DEPTH(RF_DEPTH)) u_regfile (
    .clk_i (CLK),
    .rst_ni(RST),
    .ra1_i (rs),
    .ra2_i (rt),
    .we_i  (WB_RegWrite),
    .wa_i  (WB_WriteReg),
    .wd_i  (WB_Data),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_j      = (opcode == OP_J);
  assign is_branch = is_beq | is_bne;
  assign uses_rs   = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
  assign uses_rt   = opcode inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};

  assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                    ((uses_rs && EX_WriteReg == rs) || (uses_rt && EX_WriteReg == rt));

  // Branch operands must be final in ID: anything still being computed upstream stalls.
  always_comb begin
    br_op1    = rf_rd1;
    br_op2    = rf_rd2;
    br_hazard = 1'b0;
    if (is_branch) begin
      if (rs != 5'd0) begin
        if ((EX_RegWrite && EX_WriteReg == rs) || (MEM_MemRead && MEM_WriteReg == rs))
          br_hazard = 1'b1;
        else if (MEM_RegWrite && MEM_WriteReg == rs)
`ifdef ID_FORWARD_EN
          br_op1 = MEM_ALUResult;
`else
          br_hazard = 1'b1;
`endif
      end
      if (rt != 5'd0) begin
        if ((EX_RegWrite && EX_WriteReg == rt) || (MEM_MemRead && MEM_WriteReg == rt))
          br_hazard = 1'b1;
        else if (MEM_RegWrite && MEM_WriteReg == rt)
`ifdef ID_FORWARD_EN
          br_op2 = MEM_ALUResult;
`else
          br_hazard = 1'b1;
`endif
      end
    end
  end

`ifndef ID_FORWARD_EN
  logic unused_mem_alu;
  assign unused_mem_alu = ^MEM_ALUResult;
`endif

  assign stall_raw = load_use | br_hazard;
  assign taken     = (is_beq & (br_op1 == br_op2)) | (is_bne & (br_op1 != br_op2)) | is_j;

  assign pc_plus4     = PC1 + 32'd4;
  assign br_target    = pc_plus4 + (imm_sext << 2);
  assign j_target     = {pc_plus4[31:28], Instruction1[25:0], 2'b00};
  assign BranchTarget = is_j ? j_target : br_target;

  // Gated by RST so fetch sees no stall/redirect while the stage is held in reset.
  assign Stall = RST & stall_raw;
  assign PCsrc = RST & taken & ~stall_raw;

  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (!(stall_raw || taken)) begin
      idex_d.rd1  = rf_rd1;
      idex_d.rd2  = rf_rd2;
      idex_d.imm  = imm_ext;
      idex_d.rs   = rs;
      idex_d.rt   = rt;
      idex_d.rd   = rd;
      idex_d.pc2  = PC1;
      idex_d.ctrl = ctrl;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) idex_q <= IDEX_BUBBLE;
    else      idex_q <= idex_d;
  end

  assign ReadData1 = idex_q.rd1;
  assign ReadData2 = idex_q.rd2;
  assign Imm       = idex_q.imm;
  assign Rs        = idex_q.rs;
  assign Rt        = idex_q.rt;
  assign Rd        = idex_q.rd;
  assign PC2       = idex_q.pc2;
  assign RegWrite  = idex_q.ctrl.reg_write;
  assign MemRead   = idex_q.ctrl.mem_read;
  assign MemWrite  = idex_q.ctrl.mem_write;
  assign MemToReg  = idex_q.ctrl.mem_to_reg;
  assign ALUSrc    = idex_q.ctrl.alu_src;
  assign RegDst    = idex_q.ctrl.reg_dst;
  assign ALUOp     = ALUOP_W'(idex_q.ctrl.alu_op);

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - self-checking bench: directed cases plus randomized run against a reference model
module tb_instruction_decode_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Instruction1 = '0, PC1 = '0, MEM_ALUResult = '0, WB_Data = '0;
  logic        EX_MemRead = 0, EX_RegWrite = 0, MEM_MemRead = 0, MEM_RegWrite = 0, WB_RegWrite = 0;
  logic [4:0]  EX_WriteReg = '0, MEM_WriteReg = '0, WB_WriteReg = '0;
  logic        Stall, PCsrc, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst;
  logic [31:0] BranchTarget, ReadData1, ReadData2, Imm, PC2;
  logic [4:0]  Rs, Rt, Rd;
  logic [3:0]  ALUOp;

  instruction_decode_stage dut (
    .CLK(CLK), .RST(RST), .Instruction1(Instruction1), .PC1(PC1),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
    .MEM_ALUResult(MEM_ALUResult), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_Data(WB_Data), .Stall(Stall), .PCsrc(PCsrc), .BranchTarget(BranchTarget),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .PC2(PC2), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUOp(ALUOp)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc2;
    logic [9:0]  ctl;   // {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,ALUOp}
  } idex_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mrf [32];
  idex_t       exp_idex = '0;
  idex_t       act_idex;
  logic        e_stall, e_pcsrc;
  logic [31:0] e_tgt;
  idex_t       e_next;

  assign act_idex = {ReadData1, ReadData2, Imm, Rs, Rt, Rd, PC2,
                     RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp};

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_RegWrite && WB_WriteReg == a) return WB_Data;
    return mrf[a];
  endfunction

  task automatic model();
    logic [5:0]  op;
    logic [4:0]  rs, rt, src;
    logic [15:0] i16;
    logic [31:0] a, b, pc4, simm, immx;
    logic [9:0]  ctl;
    logic        use_rs, use_rt, br, lu, hz, tk;
    op = Instruction1[31:26]; rs = Instruction1[25:21]; rt = Instruction1[20:16];
    i16 = Instruction1[15:0];
    use_rs = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    use_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    br = op inside {6'h04, 6'h05};
    lu = EX_MemRead && EX_WriteReg != 0 &&
         ((use_rs && EX_WriteReg == rs) || (use_rt && EX_WriteReg == rt));
    a = mread(rs); b = mread(rt); hz = 0;
    if (br) begin
      for (int k = 0; k < 2; k++) begin
        src = (k == 0) ? rs : rt;
        if (src != 0) begin
          if ((EX_RegWrite && EX_WriteReg == src) || (MEM_MemRead && MEM_WriteReg == src)) hz = 1;
          else if (MEM_RegWrite && MEM_WriteReg == src) begin
`ifdef ID_FORWARD_EN
            if (k == 0) a = MEM_ALUResult; else b = MEM_ALUResult;
`else
            hz = 1;
`endif
          end
        end
      end
    end
    tk = (op == 6'h04 && a == b) || (op == 6'h05 && a != b) || op == 6'h02;
    pc4 = PC1 + 32'd4;
    simm = {{16{i16[15]}}, i16};
    e_tgt = (op == 6'h02) ? {pc4[31:28], Instruction1[25:0], 2'b00} : pc4 + simm * 4;
    case (op)
      6'h00: ctl = 10'b100001_0011;
      6'h23: ctl = 10'b110110_0001;
      6'h2B: ctl = 10'b001010_0001;
      6'h04, 6'h05: ctl = 10'b000000_0010;
      6'h08: ctl = 10'b100010_0001;
      6'h0C: ctl = 10'b100010_0100;
      6'h0D: ctl = 10'b100010_0101;
      6'h0A: ctl = 10'b100010_0110;
      6'h0F: ctl = 10'b100010_0111;
      default: ctl = 10'b0;
    endcase
    if (op == 6'h0C || op == 6'h0D) immx = {16'h0, i16};
    else if (op == 6'h0F)           immx = {i16, 16'h0};
    else                            immx = simm;
    e_stall = lu || hz;
    e_pcsrc = tk && !e_stall;
    e_next = (e_stall || tk) ? '0 :
             {mread(rs), mread(rt), immx, rs, rt, Instruction1[15:11], PC1, ctl};
  endtask

  // Per-cycle comparison against the model, mid-cycle when inputs are stable.
  always @(negedge CLK) begin
    model();
    if (!RST) begin
      chk("rst_stall", Stall, 0);
      chk("rst_pcsrc", PCsrc, 0);
      chk("rst_idex", act_idex, 0);
      exp_idex = '0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
    end else begin
      chk("stall", Stall, e_stall);
      chk("pcsrc", PCsrc, e_pcsrc);
      chk("target", BranchTarget, e_tgt);
      chk("idex", act_idex, exp_idex);
      exp_idex = e_next;
      if (WB_RegWrite && WB_WriteReg != 0) mrf[WB_WriteReg] = WB_Data;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
    MEM_MemRead = 0; MEM_RegWrite = 0; MEM_WriteReg = 0; MEM_ALUResult = 0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_Data = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    quiet();
    Instruction1 = 32'h0; PC1 = 32'h0;
    WB_RegWrite = 1; WB_WriteReg = r; WB_Data = d;
    step();
    WB_RegWrite = 0;
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h02, 6'h3F};
    quiet();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1;
    wb(1, 5); wb(2, 5); wb(4, 7); wb(10, 3);

    // beq taken
    Instruction1 = {6'h04, 5'd1, 5'd2, 16'd3}; PC1 = 32'h40;
    #2; chk("beq_pcsrc", PCsrc, 1); chk("beq_target", BranchTarget, 32'h50);
    step(); chk("beq_bubble", act_idex, 0);
    // bne not taken
    Instruction1 = {6'h05, 5'd1, 5'd2, 16'd3};
    #2; chk("bne_pcsrc", PCsrc, 0); chk("bne_stall", Stall, 0);
    step(); chk("bne_rs", Rs, 1); chk("bne_pc2", PC2, 32'h40); chk("bne_aluop", ALUOp, 2);
    // j, then j with PC+4 wrap
    Instruction1 = {6'h02, 26'h10}; PC1 = 32'h1000_0004;
    #2; chk("j_target", BranchTarget, 32'h1000_0040); chk("j_pcsrc", PCsrc, 1);
    step();
    Instruction1 = {6'h02, 26'h3}; PC1 = 32'hFFFF_FFFC;
    #2; chk("j_wrap_target", BranchTarget, 32'h0000_000C);
    step();
    // load-use
    EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 8;
    Instruction1 = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20}; PC1 = 32'h200;
    #2; chk("lu_stall", Stall, 1); chk("lu_pcsrc", PCsrc, 0);
    step(); chk("lu_bubble", act_idex, 0);
    quiet();
    #2; chk("lu_release", Stall, 0);
    step(); chk("lu_rs", Rs, 8); chk("lu_rd", Rd, 9); chk("lu_regwrite", RegWrite, 1);
    chk("lu_rd2", ReadData2, 3);
    // branch on a MEM-stage ALU result
    MEM_RegWrite = 1; MEM_WriteReg = 3; MEM_ALUResult = 7;
    Instruction1 = {6'h04, 5'd3, 5'd4, 16'hFFFF}; PC1 = 32'h100;
`ifdef ID_FORWARD_EN
    #2; chk("fw_stall", Stall, 0); chk("fw_pcsrc", PCsrc, 1); chk("fw_target", BranchTarget, 32'h100);
    step();
`else
    #2; chk("mem_stall", Stall, 1); chk("mem_pcsrc", PCsrc, 0);
    step(); chk("mem_bubble", act_idex, 0);
    quiet(); WB_RegWrite = 1; WB_WriteReg = 3; WB_Data = 7;
    #2; chk("mem_resolve_stall", Stall, 0); chk("mem_resolve_pcsrc", PCsrc, 1);
    chk("mem_resolve_target", BranchTarget, 32'h100);
    step();
`endif
    quiet();
    // asynchronous reset mid-run
    Instruction1 = {6'h08, 5'd1, 5'd5, 16'd9}; PC1 = 32'h300;
    step(); chk("pre_rst_regwrite", RegWrite, 1);
    EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 1; RST = 0;
    #1; chk("rst_now_stall", Stall, 0); chk("rst_now_pcsrc", PCsrc, 0);
    chk("rst_now_idex", act_idex, 0);
    step(); RST = 1; quiet();

    for (int n = 0; n < 3000; n++) begin
      op = ops[$urandom_range(0, 11)];
      Instruction1 = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      if (op == 6'h02) Instruction1[25:0] = 26'($urandom);
      PC1 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      EX_MemRead = ($urandom_range(0, 3) == 0);
      EX_RegWrite = EX_MemRead | ($urandom_range(0, 2) == 0);
      EX_WriteReg = 5'($urandom_range(0, 7));
      MEM_MemRead = ($urandom_range(0, 3) == 0);
      MEM_RegWrite = MEM_MemRead | ($urandom_range(0, 2) == 0);
      MEM_WriteReg = 5'($urandom_range(0, 7));
      MEM_ALUResult = $urandom_range(0, 3);
      WB_RegWrite = $urandom_range(0, 1);
      WB_WriteReg = 5'($urandom_range(0, 7));
      WB_Data = $urandom_range(0, 3);
      RST = ($urandom_range(0, 199) != 0);
      step();
    end
    RST = 1; quiet();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
